// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU MEM stage
// and the debug/loader port.
package dmem_arb_pkg;

   typedef enum logic {
      NORMAL,
      DBG_PRIO
   } arb_state_e;

   typedef enum logic {
      OWN_CPU,
      OWN_DBG
   } owner_e;

   localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles in which the debug port was denied.
// sat_next flags that the count reaches LIMIT at the coming clock edge.
module arb_starve_cnt
   import dmem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = STARVE_LIMIT_DEF,
   parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
   input  logic clock,
   input  logic reset_n,
   input  logic denied,
   output logic sat_next
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // Any cycle without a denied dbg request (idle or granted) restarts the count.
   always_comb begin
      cnt_next = '0;
      if (denied) begin
         cnt_next = (cnt == CNT_W'(LIMIT)) ? cnt : cnt + CNT_W'(1);
      end
   end

   assign sat_next = (cnt_next == CNT_W'(LIMIT));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU has priority unless the debug port has starved,
// then debug wins (optionally locked across back-to-back accesses).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [31:0]       dbg_wdata,
   input  logic              dbg_lock,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [31:0]       dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              align_err
);

   arb_state_e        state;
   owner_e            owner;
   owner_e            rd_owner;
   logic              cpu_win;
   logic              dbg_win;
   logic              any_gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic              aligned;
   logic              rd_pend;
   logic              err_q;
   logic              starve_sat;

   always_comb begin
      cpu_win = cpu_req && !((state == DBG_PRIO) && dbg_req);
      dbg_win = dbg_req && !cpu_win;
      any_gnt = cpu_win || dbg_win;
      owner   = dbg_win ? OWN_DBG : OWN_CPU;
   end

   assign cpu_gnt   = cpu_win;
   assign dbg_gnt   = dbg_win;
   assign cpu_stall = cpu_req && !cpu_win;

   always_comb begin
      sel_addr  = (owner == OWN_DBG) ? dbg_addr  : cpu_addr;
      sel_we    = (owner == OWN_DBG) ? dbg_we    : cpu_we;
      sel_wdata = (owner == OWN_DBG) ? dbg_wdata : cpu_wdata;
      aligned   = (sel_addr[1:0] == 2'b00);
      mem_en    = any_gnt && aligned;
      mem_we    = mem_en && sel_we;
      mem_addr  = mem_en ? sel_addr[ADDR_W-1:2] : '0;
      mem_wdata = mem_en ? sel_wdata : '0;
   end

   arb_starve_cnt #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clock   (clock),
      .reset_n (reset_n),
      .denied  (dbg_req && !dbg_win),
      .sat_next(starve_sat)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= NORMAL;
         rd_pend  <= 1'b0;
         rd_owner <= OWN_CPU;
         err_q    <= 1'b0;
      end else begin
         unique case (state)
            NORMAL:   if (dbg_req && starve_sat) state <= DBG_PRIO;
            // A requesting dbg always wins here, so an unlocked request means one grant done.
            DBG_PRIO: if (!dbg_req || !dbg_lock) state <= NORMAL;
         endcase
         rd_pend  <= mem_en && !sel_we;
         rd_owner <= owner;
         err_q    <= any_gnt && !aligned;
      end
   end

   assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
   assign dbg_rvalid = rd_pend && (rd_owner == OWN_DBG);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
   assign align_err  = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, all checked against
// a cycle-level behavioural model with its own memory shadow.
module tb_dmem_arbiter;

   localparam int unsigned LIMIT = 4;
   localparam int unsigned AW    = 32;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata, cpu_rdata;
   logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
   logic [AW-1:0] dbg_addr;
   logic [31:0]   dbg_wdata, dbg_rdata;
   logic          mem_en, mem_we, align_err;
   logic [AW-3:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   int checks = 0;
   int passed = 0;

   dmem_arbiter #(
      .STARVE_LIMIT(LIMIT),
      .ADDR_W      (AW)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_stall (cpu_stall),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_lock  (dbg_lock),
      .dbg_gnt   (dbg_gnt),
      .dbg_rvalid(dbg_rvalid),
      .dbg_rdata (dbg_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .align_err (align_err)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] dflt(input logic [7:0] i);
      return {8'hA5, 8'h5A, i, ~i};
   endfunction

   // Memory environment: 256 words, unwritten words read back as dflt(index).
   logic [31:0]  ram [256];
   logic [255:0] ram_ok;
   logic [31:0]  ram_q;
   assign mem_rdata = ram_q;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ram_ok <= '0;
         ram_q  <= '0;
      end else if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr[7:0]]    <= mem_wdata;
            ram_ok[mem_addr[7:0]] <= 1'b1;
         end else begin
            ram_q <= ram_ok[mem_addr[7:0]] ? ram[mem_addr[7:0]] : dflt(mem_addr[7:0]);
         end
      end
   end

   // Reference model state
   bit          m_prio;
   int          m_denied;
   bit          m_rv, m_rv_dbg, m_err;
   logic [31:0] m_rd;
   logic [31:0] sh [256];
   bit          sh_ok [256];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_prio   = 1'b0;
      m_denied = 0;
      m_rv     = 1'b0;
      m_rv_dbg = 1'b0;
      m_err    = 1'b0;
      m_rd     = '0;
      for (int i = 0; i < 256; i++) sh_ok[i] = 1'b0;
   endtask

   task automatic set_idle();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
   endtask

   // Samples at the falling edge, checks every output against the model, steps the model.
   task automatic sample();
      bit          eg_c, eg_d, hit, al, en, we;
      logic [31:0] a, wd;
      logic [7:0]  idx;
      @(negedge clock);
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv && !m_rv_dbg));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rv && m_rv_dbg));
      chk("cpu_rdata", cpu_rdata, (m_rv && !m_rv_dbg) ? m_rd : 32'h0);
      chk("dbg_rdata", dbg_rdata, (m_rv && m_rv_dbg) ? m_rd : 32'h0);
      chk("align_err", 32'(align_err), 32'(m_err));
      eg_c = cpu_req && !(m_prio && dbg_req);
      eg_d = dbg_req && !eg_c;
      chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(eg_d));
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eg_c));
      hit = eg_c || eg_d;
      a   = eg_d ? dbg_addr : cpu_addr;
      we  = eg_d ? dbg_we : cpu_we;
      wd  = eg_d ? dbg_wdata : cpu_wdata;
      al  = (a % 4) == 0;
      en  = hit && al;
      chk("mem_en", 32'(mem_en), 32'(en));
      chk("mem_we", 32'(mem_we), 32'(en && we));
      if (en) chk("mem_addr", 32'(mem_addr), a / 4);
      if (en && we) chk("mem_wdata", mem_wdata, wd);
      idx      = a[9:2];
      m_err    = hit && !al;
      m_rv     = en && !we;
      m_rv_dbg = eg_d;
      m_rd     = sh_ok[idx] ? sh[idx] : dflt(idx);
      if (en && we) begin
         sh[idx]    = wd;
         sh_ok[idx] = 1'b1;
      end
      if (dbg_req && !eg_d) m_denied = (m_denied < LIMIT) ? m_denied + 1 : LIMIT;
      else m_denied = 0;
      if (!m_prio) m_prio = dbg_req && (m_denied == LIMIT);
      else if (!dbg_req || (eg_d && !dbg_lock)) m_prio = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
      chk({tag, "_cpu_stall"}, 32'(cpu_stall), 0);
      chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
      chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
      chk({tag, "_dbg_gnt"}, 32'(dbg_gnt), 0);
      chk({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 0);
      chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
      chk({tag, "_mem_en"}, 32'(mem_en), 0);
      chk({tag, "_mem_we"}, 32'(mem_we), 0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_align_err"}, 32'(align_err), 0);
   endtask

   initial begin
      reset_n = 1'b0;
      set_idle();
      model_reset();
      #12;
      chk_quiet("rst");
      reset_n = 1'b1;
      advance();

      // CPU load at 0x20 with dbg idle
      cpu_req = 1; cpu_addr = 32'h20;
      sample();
      chk("t1_gnt", 32'(cpu_gnt), 1);
      chk("t1_mem_en", 32'(mem_en), 1);
      chk("t1_mem_addr", 32'(mem_addr), 8);
      advance();
      set_idle();
      sample();
      chk("t1_rvalid", 32'(cpu_rvalid), 1);
      chk("t1_rdata", cpu_rdata, dflt(8'd8));
      advance();

      // Both requesting continuously: dbg starves 4 cycles, wins the 5th
      cpu_req = 1; cpu_addr = 32'h40;
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = 32'hCAFE_0001;
      for (int i = 1; i <= 6; i++) begin
         sample();
         if (i <= 4 || i == 6) chk($sformatf("t2_cpu_gnt%0d", i), 32'(cpu_gnt), 1);
         if (i == 5) begin
            chk("t2_dbg_gnt5", 32'(dbg_gnt), 1);
            chk("t2_stall5", 32'(cpu_stall), 1);
         end
         advance();
      end
      set_idle();
      sample();
      advance();

      // Locked debug priority: three dbg writes back to back, lock drops on the third
      cpu_req = 1; cpu_addr = 32'h44;
      dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 32'h90; dbg_wdata = 32'h1111_0000;
      for (int i = 1; i <= 8; i++) begin
         if (i >= 5) begin
            dbg_addr  = 32'h90 + 32'(4 * (i - 5));
            dbg_wdata = 32'h1111_0000 + 32'(i);
         end
         if (i == 7) dbg_lock = 0;
         sample();
         if (i >= 5 && i <= 7) begin
            chk($sformatf("t3_dbg_gnt%0d", i), 32'(dbg_gnt), 1);
            chk($sformatf("t3_stall%0d", i), 32'(cpu_stall), 1);
         end
         if (i == 8) chk("t3_back_normal", 32'(cpu_gnt), 1);
         advance();
      end
      set_idle();
      sample();
      advance();

      // Misaligned CPU store
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h22; cpu_wdata = 32'hDEAD_BEEF;
      sample();
      chk("t4_gnt", 32'(cpu_gnt), 1);
      chk("t4_mem_en", 32'(mem_en), 0);
      advance();
      set_idle();
      sample();
      chk("t4_align_err", 32'(align_err), 1);
      chk("t4_no_rvalid", 32'(cpu_rvalid), 0);
      advance();
      sample();
      chk("t4_err_pulse", 32'(align_err), 0);
      advance();

      // Alternating CPU and dbg reads every cycle
      for (int i = 0; i < 9; i++) begin
         set_idle();
         if (i < 8) begin
            if (i % 2 == 0) begin
               cpu_req = 1; cpu_addr = 32'h100 + 32'(4 * i);
            end else begin
               dbg_req = 1; dbg_addr = 32'h100 + 32'(4 * i);
            end
         end
         sample();
         if (i > 0) begin
            if ((i - 1) % 2 == 0) chk("t5_cpu_ret", cpu_rdata, dflt(8'(8'h40 + i - 1)));
            else chk("t5_dbg_ret", dbg_rdata, dflt(8'(8'h40 + i - 1)));
         end
         advance();
      end

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         cpu_req   = ($urandom_range(0, 3) != 0);
         cpu_we    = $urandom_range(0, 1) == 1;
         cpu_addr  = {22'b0, 8'($urandom), ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00};
         cpu_wdata = $urandom;
         dbg_req   = ($urandom_range(0, 2) != 0);
         dbg_we    = $urandom_range(0, 1) == 1;
         dbg_lock  = $urandom_range(0, 1) == 1;
         dbg_addr  = {22'b0, 8'($urandom), ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00};
         dbg_wdata = $urandom;
         sample();
         advance();
      end
      set_idle();
      sample();
      advance();
      sample();
      advance();

      // Reset the cycle after a dbg read grant: the read must never return
      dbg_req = 1; dbg_addr = 32'h30;
      sample();
      chk("t6_dbg_gnt", 32'(dbg_gnt), 1);
      advance();
      set_idle();
      reset_n = 1'b0;
      #2;
      chk_quiet("t6_rst");
      @(negedge clock);
      chk_quiet("t6_rst_hold");
      advance();
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         sample();
         chk($sformatf("t6_no_rvalid%0d", i), 32'(dbg_rvalid), 0);
         advance();
      end
      // First cycle pattern after reset: CPU wins from NORMAL
      cpu_req = 1; cpu_addr = 32'h8; dbg_req = 1; dbg_addr = 32'hC;
      sample();
      chk("t6_normal", 32'(cpu_gnt), 1);
      advance();
      set_idle();
      sample();
      advance();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
